// File: rtl/card_pkg.sv
// Shared card definitions for the dealer, the 7-segment display and the scoring logic.
package card_pkg;

    localparam int unsigned CARD_W = 4;

    typedef logic [CARD_W-1:0] card_t;

    localparam card_t CARD_NONE  = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_TWO   = 4'd2;
    localparam card_t CARD_THREE = 4'd3;
    localparam card_t CARD_FOUR  = 4'd4;
    localparam card_t CARD_FIVE  = 4'd5;
    localparam card_t CARD_SIX   = 4'd6;
    localparam card_t CARD_SEVEN = 4'd7;
    localparam card_t CARD_EIGHT = 4'd8;
    localparam card_t CARD_NINE  = 4'd9;
    localparam card_t CARD_TEN   = 4'd10;
    localparam card_t CARD_JACK  = 4'd11;
    localparam card_t CARD_QUEEN = 4'd12;
    localparam card_t CARD_KING  = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SCORE,
        ST_ACK,
        ST_NACK
    } deal_state_t;

    // Baccarat points: ace..nine at face value, ten and court cards worth nothing.
    function automatic card_t card_points(input card_t c);
        return (c >= CARD_ACE && c <= CARD_NINE) ? c : CARD_NONE;
    endfunction

endpackage

// File: rtl/card_counter.sv
// Free-running 1..MAXCARD card source; player timing of the request supplies the randomness.
module card_counter
    import card_pkg::*;
#(
    parameter int unsigned MAXCARD = 13
) (
    input  logic  clock,
    input  logic  resetb,
    output card_t card
);

    // Compare with >= so an out-of-range value can never persist.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            card <= CARD_ACE;
        end else if (card >= CARD_W'(MAXCARD)) begin
            card <= CARD_ACE;
        end else begin
            card <= card + CARD_W'(1);
        end
    end

endmodule

// File: rtl/hand_dealer.sv
// Deals counter cards into a three-slot hand on a 4-phase req/ack handshake and keeps the baccarat score.
module hand_dealer
    import card_pkg::*;
#(
    parameter  int unsigned NSLOTS  = 3,
    parameter  int unsigned MAXCARD = 13,
    localparam int unsigned CNT_W   = $clog2(NSLOTS + 1)
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             deal_req,
    input  logic             clear,
    output card_t            card1,
    output card_t            card2,
    output card_t            card3,
    output logic [CNT_W-1:0] hand_count,
    output logic [3:0]       score,
    output logic             deal_ack,
    output logic             deal_nack
);

    localparam int unsigned SUM_W = 5;

    deal_state_t      state;
    deal_state_t      state_nxt;
    card_t            cur_card;
    card_t            dealt;
    logic [SUM_W-1:0] sum;
    logic [3:0]       score_nxt;

    card_counter #(.MAXCARD(MAXCARD)) u_counter (
        .clock  (clock),
        .resetb (resetb),
        .card   (cur_card)
    );

    // Next-state decode; clear overrides everything, including an in-flight deal.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (deal_req) begin
                    state_nxt = (hand_count >= CNT_W'(NSLOTS)) ? ST_NACK : ST_LATCH;
                end
            end
            ST_LATCH: state_nxt = ST_SCORE;
            ST_SCORE: state_nxt = ST_ACK;
            ST_ACK:   if (!deal_req) state_nxt = ST_IDLE;
            ST_NACK:  if (!deal_req) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    // Mod-10 score accumulate on a 5-bit sum.
    always_comb begin
        sum       = SUM_W'(score) + SUM_W'(card_points(dealt));
        score_nxt = (sum >= SUM_W'(10)) ? 4'(sum - SUM_W'(10)) : 4'(sum);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            card1      <= CARD_NONE;
            card2      <= CARD_NONE;
            card3      <= CARD_NONE;
            dealt      <= CARD_NONE;
            hand_count <= '0;
            score      <= '0;
            deal_ack   <= 1'b0;
            deal_nack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            deal_ack  <= (state_nxt == ST_ACK);
            deal_nack <= (state_nxt == ST_NACK);
            if (clear) begin
                card1      <= CARD_NONE;
                card2      <= CARD_NONE;
                card3      <= CARD_NONE;
                dealt      <= CARD_NONE;
                hand_count <= '0;
                score      <= '0;
            end else begin
                case (state)
                    ST_LATCH: begin
                        case (hand_count)
                            CNT_W'(0): card1 <= cur_card;
                            CNT_W'(1): card2 <= cur_card;
                            default:   card3 <= cur_card;
                        endcase
                        dealt      <= cur_card;
                        hand_count <= hand_count + CNT_W'(1);
                    end
                    ST_SCORE: score <= score_nxt;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hand_dealer.sv
// Directed self-checking bench for hand_dealer.
module tb_hand_dealer;
    import card_pkg::*;

    logic       clock = 1'b0;
    logic       resetb;
    logic       deal_req;
    logic       clear;
    logic [3:0] card1, card2, card3;
    logic [1:0] hand_count;
    logic [3:0] score;
    logic       deal_ack, deal_nack;

    int checks = 0;
    int errors = 0;

    // Reference card counter used only to time requests.
    logic [3:0] mcnt;

    hand_dealer dut (
        .clock      (clock),
        .resetb     (resetb),
        .deal_req   (deal_req),
        .clear      (clear),
        .card1      (card1),
        .card2      (card2),
        .card3      (card3),
        .hand_count (hand_count),
        .score      (score),
        .deal_ack   (deal_ack),
        .deal_nack  (deal_nack)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge resetb) begin
        if (!resetb) mcnt <= 4'd1;
        else         mcnt <= (mcnt == 4'd13) ? 4'd1 : mcnt + 4'd1;
    end

    function automatic logic [3:0] slot_val(input int s);
        return (s == 1) ? card1 : (s == 2) ? card2 : card3;
    endfunction

    task automatic wait_counter(input logic [3:0] v);
        logic [3:0] pv;
        bit found;
        pv = (v == 4'd1) ? 4'd13 : v - 4'd1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (mcnt == pv) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_counter: value %0d never reached", pv);
        end
    endtask

    task automatic deal(input logic [3:0] v, input int slot, input logic [3:0] exp_score,
                        input logic [1:0] exp_count);
        wait_counter(v);
        deal_req = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (deal_ack !== 1'b0) begin
            errors++; $display("FAIL deal_ack_e0: got %b want 0", deal_ack);
        end
        @(posedge clock); #1;
        checks++;
        if (deal_ack !== 1'b0 || slot_val(slot) !== v || hand_count !== exp_count) begin
            errors++;
            $display("FAIL deal_latch: ack %b card%0d %0d count %0d want ack 0 card %0d count %0d",
                     deal_ack, slot, slot_val(slot), hand_count, v, exp_count);
        end
        @(posedge clock); #1;
        checks++;
        if (deal_ack !== 1'b1 || score !== exp_score) begin
            errors++;
            $display("FAIL deal_ack_score: ack %b score %0d want ack 1 score %0d",
                     deal_ack, score, exp_score);
        end
        deal_req = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (deal_ack !== 1'b0) begin
            errors++; $display("FAIL deal_ack_fall: got %b want 0", deal_ack);
        end
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (card1 !== 4'd0 || card2 !== 4'd0 || card3 !== 4'd0 || hand_count !== 2'd0 ||
            score !== 4'd0 || dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL clear: cards %0d %0d %0d count %0d score %0d want all 0",
                     card1, card2, card3, hand_count, score);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        resetb = 1'b0; deal_req = 1'b0; clear = 1'b0;
        #3;
        checks++;
        if (card1 !== 4'd0 || card2 !== 4'd0 || card3 !== 4'd0 || hand_count !== 2'd0 ||
            score !== 4'd0 || deal_ack !== 1'b0 || deal_nack !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: outputs not all 0");
        end
        @(negedge clock); @(negedge clock);
        resetb = 1'b1;
        checks++;
        if (dut.u_counter.card !== 4'd1) begin
            errors++; $display("FAIL reset_counter: got %0d want 1", dut.u_counter.card);
        end
        exp = 4'd1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            exp = (exp == 4'd13) ? 4'd1 : exp + 4'd1;
            checks++;
            if (dut.u_counter.card !== exp) begin
                errors++;
                $display("FAIL counter_step%0d: got %0d want %0d", i, dut.u_counter.card, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clock);
        deal_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock); #1;
            if (deal_ack === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_ack: ack never rose, got %b want 1", deal_ack);
        end
        #2;
        resetb = 1'b0;
        #1;
        checks++;
        if (deal_ack !== 1'b0 || card1 !== 4'd0 || hand_count !== 2'd0 || score !== 4'd0 ||
            dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid: ack %b card1 %0d count %0d score %0d want all 0",
                     deal_ack, card1, hand_count, score);
        end
        deal_req = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
    endtask

    task automatic test_three_deals();
        deal(4'd7,  1, 4'd7, 2'd1);
        deal(4'd5,  2, 4'd2, 2'd2);
        deal(4'd12, 3, 4'd2, 2'd3);
    endtask

    task automatic test_full_hand();
        @(negedge clock);
        deal_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            checks++;
            if (deal_nack !== 1'b1 || deal_ack !== 1'b0 || card1 !== 4'd7 || card2 !== 4'd5 ||
                card3 !== 4'd12 || score !== 4'd2 || hand_count !== 2'd3) begin
                errors++;
                $display("FAIL full_nack: nack %b ack %b cards %0d %0d %0d score %0d count %0d want 1 0 7 5 12 2 3",
                         deal_nack, deal_ack, card1, card2, card3, score, hand_count);
            end
        end
        deal_req = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (deal_nack !== 1'b0) begin
            errors++; $display("FAIL full_nack_fall: got %b want 0", deal_nack);
        end
    endtask

    task automatic test_clear_mid();
        bit bad;
        do_clear();
        @(negedge clock);
        deal_req = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (dut.state !== ST_SCORE || hand_count !== 2'd1) begin
            errors++; $display("FAIL clear_mid_setup: count %0d want 1 in SCORE", hand_count);
        end
        @(negedge clock);
        clear = 1'b1;
        deal_req = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (card1 !== 4'd0 || hand_count !== 2'd0 || score !== 4'd0 || deal_ack !== 1'b0 ||
            dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL clear_mid: card1 %0d count %0d score %0d ack %b want 0 0 0 0",
                     card1, hand_count, score, deal_ack);
        end
        @(negedge clock);
        clear = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (deal_ack !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL clear_mid_noack: ack seen, want none");
        end
    endtask

    task automatic test_held_high();
        bit bad;
        do_clear();
        wait_counter(4'd4);
        deal_req = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (deal_ack !== 1'b1 || card1 !== 4'd4) begin
            errors++; $display("FAIL held_ack: ack %b card1 %0d want 1 4", deal_ack, card1);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (deal_ack !== 1'b1 || hand_count !== 2'd1 || card2 !== 4'd0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL held_single: count %0d card2 %0d want 1 0", hand_count, card2);
        end
        deal_req = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (deal_ack !== 1'b0 || hand_count !== 2'd1) begin
            errors++; $display("FAIL held_release: ack %b count %0d want 0 1", deal_ack, hand_count);
        end
    endtask

    task automatic test_face_scoring();
        do_clear();
        deal(4'd10, 1, 4'd0, 2'd1);
        deal(4'd11, 2, 4'd0, 2'd2);
        deal(4'd13, 3, 4'd0, 2'd3);
        do_clear();
        deal(4'd9, 1, 4'd9, 2'd1);
        deal(4'd3, 2, 4'd2, 2'd2);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_three_deals();
        test_full_hand();
        test_clear_mid();
        test_held_high();
        test_face_scoring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
